// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - registered-read instruction memory with stall and streaming program load
module instr_mem_sync #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 12,
    parameter int                DEPTH    = 4096,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(16'h0000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              stall,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              addr_err,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              busy
);

    localparam int             IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic              beat;
    logic              load_end;
    logic              pc_oob;
    logic [DATA_W-1:0] mem [DEPTH];

    assign beat       = (state == LOAD) && load_valid;
    // The load ends on an explicit last beat or when the top word is written; no wrap.
    assign load_end   = beat && (load_last || (load_count == LAST_C));
    assign pc_oob     = ({1'b0, fetch_pc} >= DEPTH_C);
    assign load_ready = (state == LOAD);
    assign busy       = (state == LOAD);

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (load_start) state_next = LOAD;
            LOAD:    if (load_end)   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            load_count <= '0;
            load_done  <= 1'b0;
        end else begin
            state     <= state_next;
            load_done <= load_end;
            if ((state == RUN) && load_start) begin
                load_count <= '0;
            end else if (beat) begin
                load_count <= load_count + 1'b1;
            end
        end
    end

    // Array has no reset so contents survive a reset; writes are suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (beat && !reset) begin
            mem[load_count[IDX_W-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            fetch_instr <= NOP_WORD;
            addr_err    <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            if ((state == LOAD) || load_start) begin
                fetch_valid <= 1'b0;
                fetch_instr <= NOP_WORD;
            end else if (stall) begin
                fetch_valid <= fetch_valid;
                fetch_instr <= fetch_instr;
            end else if (fetch_req) begin
                fetch_valid <= 1'b1;
                addr_err    <= pc_oob;
                fetch_instr <= pc_oob ? NOP_WORD : mem[fetch_pc[IDX_W-1:0]];
            end else begin
                fetch_valid <= 1'b0;
                fetch_instr <= NOP_WORD;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// tb/tb_instr_mem_sync.sv - directed checks of instr_mem_sync at default size and at DEPTH=8/ADDR_W=4
module tb_instr_mem_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        fetch_req;
    logic [11:0] fetch_pc;
    logic        stall;
    logic        load_start;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;

    logic        b_valid, b_err, b_ready, b_done, b_busy;
    logic [15:0] b_instr;
    logic [12:0] b_count;
    logic        s_valid, s_err, s_ready, s_done, s_busy;
    logic [15:0] s_instr;
    logic [4:0]  s_count;

    logic        o_valid, o_err, o_ready, o_done, o_busy;
    logic [15:0] o_instr;
    logic [12:0] o_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_mem_sync dut_big (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req & ~sel), .fetch_pc(fetch_pc), .stall(stall & ~sel),
        .fetch_valid(b_valid), .fetch_instr(b_instr), .addr_err(b_err),
        .load_start(load_start & ~sel), .load_valid(load_valid & ~sel),
        .load_data(load_data), .load_last(load_last & ~sel),
        .load_ready(b_ready), .load_done(b_done), .load_count(b_count), .busy(b_busy)
    );

    instr_mem_sync #(.DATA_W(16), .ADDR_W(4), .DEPTH(8), .NOP_WORD(16'h0000)) dut_small (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req & sel), .fetch_pc(fetch_pc[3:0]), .stall(stall & sel),
        .fetch_valid(s_valid), .fetch_instr(s_instr), .addr_err(s_err),
        .load_start(load_start & sel), .load_valid(load_valid & sel),
        .load_data(load_data), .load_last(load_last & sel),
        .load_ready(s_ready), .load_done(s_done), .load_count(s_count), .busy(s_busy)
    );

    assign o_valid = sel ? s_valid : b_valid;
    assign o_err   = sel ? s_err   : b_err;
    assign o_ready = sel ? s_ready : b_ready;
    assign o_done  = sel ? s_done  : b_done;
    assign o_busy  = sel ? s_busy  : b_busy;
    assign o_instr = sel ? s_instr : b_instr;
    assign o_count = sel ? {8'd0, s_count} : b_count;

    typedef struct {
        string       name;
        logic        req;
        logic        stl;
        logic [11:0] pc;
        logic        exp_valid;
        logic [15:0] exp_instr;
        logic        exp_err;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fetch(input string name, input logic [11:0] pc, input logic [15:0] exp);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        step();
        check({name, "_valid"}, o_valid, 1);
        check({name, "_instr"}, o_instr, exp);
        check({name, "_err"}, o_err, 0);
        fetch_req = 1'b0;
    endtask

    logic [15:0] prog [9];
    vec_t        vecs [13];

    initial begin
        prog = '{16'h6181, 16'h6242, 16'h6313, 16'h6414, 16'h7111,
                 16'h9114, 16'h6142, 16'h6243, 16'h2324};
        vecs = '{
            '{"pc5",      1'b1, 1'b0, 12'd5, 1'b1, 16'h9114, 1'b0},
            '{"pc0",      1'b1, 1'b0, 12'd0, 1'b1, 16'h6181, 1'b0},
            '{"pc1",      1'b1, 1'b0, 12'd1, 1'b1, 16'h6242, 1'b0},
            '{"pc2",      1'b1, 1'b0, 12'd2, 1'b1, 16'h6313, 1'b0},
            '{"idle",     1'b0, 1'b0, 12'd2, 1'b0, 16'h0000, 1'b0},
            '{"pc3",      1'b1, 1'b0, 12'd3, 1'b1, 16'h6414, 1'b0},
            '{"stall1",   1'b1, 1'b1, 12'd7, 1'b1, 16'h6414, 1'b0},
            '{"stall2",   1'b1, 1'b1, 12'd7, 1'b1, 16'h6414, 1'b0},
            '{"stall3",   1'b0, 1'b1, 12'd7, 1'b1, 16'h6414, 1'b0},
            '{"pc7",      1'b1, 1'b0, 12'd7, 1'b1, 16'h6243, 1'b0},
            '{"pc8",      1'b1, 1'b0, 12'd8, 1'b1, 16'h2324, 1'b0},
            '{"idle2",    1'b0, 1'b0, 12'd8, 1'b0, 16'h0000, 1'b0},
            '{"stall_nv", 1'b1, 1'b1, 12'd1, 1'b0, 16'h0000, 1'b0}
        };

        reset = 1'b1; sel = 1'b0; fetch_req = 1'b0; fetch_pc = '0; stall = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        step();
        step();
        check("rst_valid", o_valid, 0);
        check("rst_instr", o_instr, 16'h0000);
        check("rst_err",   o_err,   0);
        check("rst_ready", o_ready, 0);
        check("rst_done",  o_done,  0);
        check("rst_count", o_count, 0);
        check("rst_busy",  o_busy,  0);
        reset = 1'b0;

        // 9-word program load terminated by load_last
        load_start = 1'b1;
        step();
        check("ld_busy",  o_busy,  1);
        check("ld_ready", o_ready, 1);
        check("ld_count0", o_count, 0);
        load_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = (i == 8);
            step();
            if (i < 8) begin
                check("ld_count", o_count, i + 1);
                check("ld_nodone", o_done, 0);
            end
        end
        check("ld_done",   o_done,  1);
        check("ld_count9", o_count, 9);
        check("ld_idle",   o_busy,  0);
        check("ld_noready", o_ready, 0);
        load_valid = 1'b0; load_last = 1'b0;
        step();
        check("ld_done_pulse", o_done, 0);
        check("ld_count_hold", o_count, 9);

        foreach (vecs[i]) begin
            fetch_req = vecs[i].req;
            stall     = vecs[i].stl;
            fetch_pc  = vecs[i].pc;
            step();
            check({vecs[i].name, "_valid"}, o_valid, vecs[i].exp_valid);
            check({vecs[i].name, "_instr"}, o_instr, vecs[i].exp_instr);
            check({vecs[i].name, "_err"},   o_err,   vecs[i].exp_err);
        end
        fetch_req = 1'b0; stall = 1'b0;

        // load_start beats a same-cycle fetch; load_valid gaps; fetch ignored in LOAD
        fetch_req = 1'b1; fetch_pc = 12'd0; load_start = 1'b1;
        step();
        check("ls_win_valid", o_valid, 0);
        check("ls_win_busy",  o_busy,  1);
        fetch_req = 1'b0; load_start = 1'b0;
        load_valid = 1'b1; load_data = 16'h1111;
        step();
        check("gap_count1", o_count, 1);
        load_valid = 1'b0; fetch_req = 1'b1; fetch_pc = 12'd5;
        for (int i = 0; i < 2; i++) begin
            step();
            check("gap_count", o_count, 1);
            check("gap_fvalid", o_valid, 0);
            check("gap_finstr", o_instr, 16'h0000);
        end
        fetch_req = 1'b0;
        load_valid = 1'b1; load_data = 16'h2222; load_last = 1'b1;
        step();
        check("gap_done",   o_done,  1);
        check("gap_count2", o_count, 2);
        load_valid = 1'b0; load_last = 1'b0;
        fetch("gap_pc0", 12'd0, 16'h1111);
        fetch("gap_pc1", 12'd1, 16'h2222);
        fetch("gap_pc2", 12'd2, 16'h6313);

        // reset in the middle of a 6-word load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = 16'h3333 + 16'(i) * 16'h1111;
            step();
        end
        check("mid_count3", o_count, 3);
        reset = 1'b1; load_data = 16'h6666;
        step();
        check("mid_busy",  o_busy,  0);
        check("mid_count", o_count, 0);
        check("mid_done",  o_done,  0);
        reset = 1'b0; load_valid = 1'b0;
        step();
        check("mid_done2", o_done, 0);
        check("mid_busy2", o_busy, 0);
        fetch("mid_pc0", 12'd0, 16'h3333);
        fetch("mid_pc1", 12'd1, 16'h4444);
        fetch("mid_pc2", 12'd2, 16'h5555);
        fetch("mid_pc3", 12'd3, 16'h6414);

        // reset wins over stall
        fetch("rs_pc4", 12'd4, 16'h7111);
        reset = 1'b1; stall = 1'b1; fetch_req = 1'b1;
        step();
        check("rs_valid", o_valid, 0);
        check("rs_instr", o_instr, 16'h0000);
        reset = 1'b0; stall = 1'b0; fetch_req = 1'b0;
        step();

        // DEPTH=8 instance: auto-terminate after word 8, ignore load_start in LOAD, out-of-range fetch
        sel = 1'b1;
        step();
        load_start = 1'b1;
        step();
        check("sm_busy", o_busy, 1);
        load_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            load_valid = 1'b1;
            load_data  = 16'hA000 + 16'(i);
            load_start = (i == 2);
            step();
            if (i < 7) begin
                check("sm_count", o_count, i + 1);
                check("sm_busy_ld", o_busy, 1);
            end else if (i == 7) begin
                check("sm_done",   o_done,  1);
                check("sm_count8", o_count, 8);
                check("sm_idle",   o_busy,  0);
            end else begin
                check("sm_count_hold", o_count, 8);
                check("sm_done_once",  o_done,  0);
                check("sm_stay_run",   o_busy,  0);
            end
        end
        load_valid = 1'b0; load_start = 1'b0;
        fetch_req = 1'b1; fetch_pc = 12'd9;
        step();
        check("oob_valid", o_valid, 1);
        check("oob_instr", o_instr, 16'h0000);
        check("oob_err",   o_err,   1);
        fetch_req = 1'b0;
        step();
        check("oob_err_pulse", o_err, 0);
        check("oob_idle_valid", o_valid, 0);
        fetch("sm_pc7", 12'd7, 16'hA007);
        fetch("sm_pc0", 12'd0, 16'hA000);
        fetch_req = 1'b1; fetch_pc = 12'd9; stall = 1'b1;
        step();
        check("sm_stall_instr", o_instr, 16'hA000);
        check("sm_stall_err",   o_err,   0);
        fetch_req = 1'b0; stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
